// File: rtl/demux_sel_sequencer.sv
// Break-before-make select/enable sequencer for the NOR-gate 1:4 demux.
// Define RR_SCAN_EN to pick channels from an internal round-robin pointer.
module demux_sel_sequencer #(
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned HOLD_CYCLES  = 4,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [1:0] req_ch,
   input  logic       cancel,
   output logic       ready,
   output logic       sel_a,
   output logic       sel_b,
   output logic       en,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACTIVE,
      RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       ch;

   assign cnt_d = cnt_q + 1'b1;

`ifdef RR_SCAN_EN
   logic [1:0] ptr_q;
   logic [1:0] ptr_d;
   logic       unused_req_ch;

   assign ptr_d         = ptr_q + 2'd1;
   assign ch            = ptr_q;
   assign unused_req_ch = ^req_ch;
`else
   assign ch = req_ch;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready   <= 1'b1;
         sel_a   <= 1'b0;
         sel_b   <= 1'b0;
         en      <= 1'b0;
         done    <= 1'b0;
`ifdef RR_SCAN_EN
         ptr_q   <= 2'd0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  {sel_a, sel_b} <= ch;
                  ready          <= 1'b0;
                  cnt_q          <= '0;
                  state_q        <= SETUP;
               end
            end
            SETUP: begin
               if (cancel) begin
                  state_q <= RELEASE;
               end else if (cnt_q == SETUP_LAST) begin
                  en      <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ACTIVE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ACTIVE: begin
               if (cancel) begin
                  en      <= 1'b0;
                  state_q <= RELEASE;
               end else if (cnt_q == HOLD_LAST) begin
                  en      <= 1'b0;
                  done    <= 1'b1;
                  state_q <= RELEASE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RELEASE: begin
`ifdef RR_SCAN_EN
               // only a completed transfer moves the scan on
               if (done) ptr_q <= ptr_d;
`endif
               done    <= 1'b0;
               ready   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Randomised bench for demux_sel_sequencer against a timestamp-based model.
// Build with RR_SCAN_EN to exercise the round-robin channel source.
module tb_demux_sel_sequencer;

   localparam int S = 1;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req;
   logic [1:0] req_ch;
   logic       cancel;
   logic       ready;
   logic       sel_a;
   logic       sel_b;
   logic       en;
   logic       done;

   int n_chk  = 0;
   int n_fail = 0;

   demux_sel_sequencer #(
      .SETUP_CYCLES(S),
      .HOLD_CYCLES (H),
      .CNT_W       (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .req_ch(req_ch),
      .cancel(cancel),
      .ready (ready),
      .sel_a (sel_a),
      .sel_b (sel_b),
      .en    (en),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Model: a transfer is an accept edge t0 and an end edge tend
   // (edge that enters RELEASE); cancel pulls tend in and clears norm.
   int         t = 0;
   bit         busy_m = 0;
   bit         norm_m = 0;
   int         t0_m = 0;
   int         tend_m = 0;
   logic [1:0] sel_m = 2'd0;
   logic [1:0] ptr_m = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge %0d: got %0h expected %0h",
                  tag, t, got, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic [1:0] ch,
                             input logic c, input logic rn);
      if (!rn) begin
         busy_m = 0;
         norm_m = 0;
         sel_m  = 2'd0;
         ptr_m  = 2'd0;
      end else if (!busy_m) begin
         if (r) begin
            busy_m = 1;
            norm_m = 1;
            t0_m   = t;
            tend_m = t + S + H;
`ifdef RR_SCAN_EN
            sel_m  = ptr_m;
`else
            sel_m  = ch;
`endif
         end
      end else if (t == tend_m + 1) begin
         busy_m = 0;
         if (norm_m) ptr_m = ptr_m + 2'd1;
      end else if (c && norm_m && t <= tend_m) begin
         tend_m = t;
         norm_m = 0;
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] ch,
                      input logic c, input logic rn);
      logic exp_en;
      logic exp_done;
      req    = r;
      req_ch = ch;
      cancel = c;
      rst_n  = rn;
      @(posedge clk);
      model_edge(r, ch, c, rn);
      #1;
      exp_en   = busy_m && (t >= t0_m + S) && (t < tend_m);
      exp_done = busy_m && norm_m && (t == tend_m);
      chk("ready", 32'(ready), 32'(!busy_m));
      chk("sel", 32'({sel_a, sel_b}), 32'(sel_m));
      chk("en", 32'(en), 32'(exp_en));
      chk("done", 32'(done), 32'(exp_done));
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b1);
   endtask

   initial begin
      // reset held with req asserted
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);

      // plain ch2 transfer
      cyc(1'b1, 2'd2, 1'b0, 1'b1);
      idle(7);

      // request while busy is dropped
      cyc(1'b1, 2'd1, 1'b0, 1'b1);
      idle(1);
      cyc(1'b1, 2'd3, 1'b0, 1'b1);
      idle(6);

      // cancel during ACTIVE
      cyc(1'b1, 2'd0, 1'b0, 1'b1);
      idle(1);
      cyc(1'b0, 2'd0, 1'b1, 1'b1);
      idle(3);

      // cancel during SETUP, and cancel together with req in IDLE
      cyc(1'b1, 2'd3, 1'b1, 1'b1);
      cyc(1'b0, 2'd0, 1'b1, 1'b1);
      idle(3);

      // reset in the middle of ACTIVE
      cyc(1'b1, 2'd1, 1'b0, 1'b1);
      idle(2);
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
      idle(2);

      // back-to-back requests held high, then a cancelled one
      for (int i = 0; i < 30; i++) cyc(1'b1, 2'd3, 1'b0, 1'b1);
      idle(1);
      cyc(1'b1, 2'd3, 1'b0, 1'b1);
      cyc(1'b0, 2'd0, 1'b1, 1'b1);
      idle(2);
      cyc(1'b1, 2'd3, 1'b0, 1'b1);
      idle(7);

      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 49) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
